// File: rtl/classify_sequencer.sv
// Initiator-side sequencer for the classifier start/ready handshake: issues one
// start per sample, waits for ready to fall then rise, and scores max_index against the label.
module classify_sequencer #(
   parameter int NUM_SAMPLES = 750,
   parameter int IDX_W       = 11,
   parameter int CLASS_W     = 5,
   parameter int TIMEOUT     = 4095
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               go,
   input  logic               ready_circuit,
   input  logic [CLASS_W-1:0] max_index,
   input  logic [CLASS_W-1:0] label,
   output logic               start_circuit,
   output logic [IDX_W-1:0]   dataGroupNumber,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [IDX_W-1:0]   correct_count,
   output logic [IDX_W-1:0]   sample_count,
   output logic [CLASS_W-1:0] last_pred,
   output logic               last_match
);

   localparam int                TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CAPTURE,
      S_NEXT,
      S_FINISH,
      S_ABORT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TMR_W-1:0] timer;
   logic             match;

   assign match = (max_index == label);

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (go) state_nxt = S_ISSUE;
         S_ISSUE:     state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            // A ready seen in the final allowed wait cycle still wins over the abort.
            if (!ready_circuit)        state_nxt = S_WAIT_DONE;
            else if (timer == TMR_LAST) state_nxt = S_ABORT;
         end
         S_WAIT_DONE: begin
            if (ready_circuit)          state_nxt = S_CAPTURE;
            else if (timer == TMR_LAST) state_nxt = S_ABORT;
         end
         S_CAPTURE:   state_nxt = (dataGroupNumber == LAST_IDX) ? S_FINISH : S_NEXT;
         S_NEXT:      state_nxt = S_ISSUE;
         S_FINISH:    state_nxt = S_IDLE;
         S_ABORT:     state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         // The timer restarts on every state change, so each wait state starts counting from zero.
         if ((state_nxt == state) && ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)))
            timer <= timer + 1'b1;
         else
            timer <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_circuit   <= 1'b0;
         dataGroupNumber <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         timeout_err     <= 1'b0;
         correct_count   <= '0;
         sample_count    <= '0;
         last_pred       <= '0;
         last_match      <= 1'b0;
      end else begin
         start_circuit <= (state_nxt == S_ISSUE);
         done          <= (state_nxt == S_FINISH) || (state_nxt == S_ABORT);

         if ((state == S_IDLE) && go) begin
            busy            <= 1'b1;
            dataGroupNumber <= '0;
            correct_count   <= '0;
            sample_count    <= '0;
            last_pred       <= '0;
            last_match      <= 1'b0;
            timeout_err     <= 1'b0;
         end

         if (state_nxt == S_ABORT) timeout_err <= 1'b1;

         if ((state == S_FINISH) || (state == S_ABORT)) busy <= 1'b0;

         if (state == S_CAPTURE) begin
            last_pred     <= max_index;
            last_match    <= match;
            correct_count <= correct_count + IDX_W'(match);
            sample_count  <= sample_count + 1'b1;
         end

         if (state == S_NEXT) dataGroupNumber <= dataGroupNumber + 1'b1;
      end
   end

endmodule

// File: tb/tb_classify_sequencer.sv
// Bench for classify_sequencer: a plan-driven classifier responder plus an event-time
// model that predicts every output each cycle from the handshake rules.
module tb_classify_sequencer;

   localparam int NS = 8;
   localparam int IW = 11;
   localparam int CW = 5;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          go = 1'b0;
   logic          ready_circuit = 1'b1;
   logic [CW-1:0] max_index = '0;
   logic [CW-1:0] label;
   logic          start_circuit;
   logic [IW-1:0] dataGroupNumber;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [IW-1:0] correct_count;
   logic [IW-1:0] sample_count;
   logic [CW-1:0] last_pred;
   logic          last_match;

   logic [CW-1:0] lbl_rom [NS];

   classify_sequencer #(
      .NUM_SAMPLES(NS),
      .IDX_W      (IW),
      .CLASS_W    (CW),
      .TIMEOUT    (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .go             (go),
      .ready_circuit  (ready_circuit),
      .max_index      (max_index),
      .label          (label),
      .start_circuit  (start_circuit),
      .dataGroupNumber(dataGroupNumber),
      .busy           (busy),
      .done           (done),
      .timeout_err    (timeout_err),
      .correct_count  (correct_count),
      .sample_count   (sample_count),
      .last_pred      (last_pred),
      .last_match     (last_match)
   );

   always #5 clk = ~clk;

   assign label = (dataGroupNumber < IW'(NS)) ? lbl_rom[dataGroupNumber[2:0]] : '0;

   int n_checks = 0;
   int n_pass   = 0;

   // Per-run plan: d1 = cycles ready stays high after start, d2 = cycles ready stays low.
   int d1 [NS];
   int d2 [NS];
   int pred [NS];
   int st [NS];
   int rr [NS];
   int n_started, n_done_s, end_c;
   bit aborted;

   int m_dgn, m_cor, m_smp, m_lp, m_lm, m_to;
   int e_start, e_done, e_busy, e_dgn, e_cor, e_smp, e_lp, e_lm, e_to;
   int q_starts [$];
   int done_cycle;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
   endtask

   task automatic cmp_all();
      check("start_circuit",   32'(start_circuit),   32'(e_start));
      check("done",            32'(done),            32'(e_done));
      check("busy",            32'(busy),            32'(e_busy));
      check("dataGroupNumber", 32'(dataGroupNumber), 32'(e_dgn));
      check("correct_count",   32'(correct_count),   32'(e_cor));
      check("sample_count",    32'(sample_count),    32'(e_smp));
      check("last_pred",       32'(last_pred),       32'(e_lp));
      check("last_match",      32'(last_match),      32'(e_lm));
      check("timeout_err",     32'(timeout_err),     32'(e_to));
   endtask

   task automatic expect_idle();
      e_start = 0; e_done = 0; e_busy = 0;
      e_dgn = m_dgn; e_cor = m_cor; e_smp = m_smp;
      e_lp = m_lp; e_lm = m_lm; e_to = m_to;
   endtask

   // Event times relative to the first ISSUE cycle (cycle 0) of a run.
   task automatic plan();
      int s;
      s = 0; aborted = 0; n_started = 0; end_c = 0;
      for (int k = 0; k < NS; k++) begin
         st[k] = s;
         n_started = k + 1;
         if (d1[k] > TO) begin end_c = s + TO + 1; aborted = 1; break; end
         if (d2[k] > TO) begin end_c = s + d1[k] + TO + 1; aborted = 1; break; end
         rr[k] = s + d1[k] + d2[k];
         if (k == NS - 1) end_c = rr[k] + 2;
         else             s = rr[k] + 3;
      end
      n_done_s = aborted ? n_started - 1 : n_started;
   endtask

   task automatic model_at(input int c);
      e_start = 0; e_dgn = 0; e_cor = 0; e_smp = 0; e_lp = 0; e_lm = 0;
      for (int k = 0; k < n_started; k++) begin
         if (st[k] == c) e_start = 1;
         if (st[k] <= c) e_dgn = k;
      end
      for (int k = 0; k < n_done_s; k++) begin
         if (rr[k] + 2 <= c) begin
            e_smp++;
            if (pred[k] == int'(lbl_rom[k])) e_cor++;
            e_lp = pred[k];
            e_lm = (pred[k] == int'(lbl_rom[k])) ? 1 : 0;
         end
      end
      e_done = (c == end_c) ? 1 : 0;
      e_busy = (c <= end_c) ? 1 : 0;
      e_to   = (aborted && c >= end_c) ? 1 : 0;
   endtask

   task automatic drive_at(input int c);
      int k;
      k = 0;
      for (int kk = 0; kk < n_started; kk++) if (st[kk] <= c) k = kk;
      if (c < st[k] + d1[k]) begin
         ready_circuit = 1'b1;
      end else if (k < n_done_s && c >= rr[k]) begin
         ready_circuit = 1'b1;
         max_index = CW'(pred[k]);
      end else begin
         ready_circuit = 1'b0;
         max_index = CW'($urandom_range(0, 31));
      end
   endtask

   task automatic rand_plan();
      for (int k = 0; k < NS; k++) begin
         lbl_rom[k] = CW'($urandom_range(0, 31));
         d1[k] = $urandom_range(1, 6);
         d2[k] = $urandom_range(1, 12);
         pred[k] = ($urandom_range(0, 1) == 1) ? int'(lbl_rom[k]) : $urandom_range(0, 31);
      end
   endtask

   task automatic run_seq(input bit chained, input bit go_hold, input int rst_sample);
      int rst_at;
      plan();
      rst_at = (rst_sample >= 0) ? st[rst_sample] + d1[rst_sample] + 1 : -1;
      q_starts.delete();
      done_cycle = -1;
      if (!chained) begin
         @(posedge clk); #1;
         go = 1'b1;
         ready_circuit = 1'b1;
         expect_idle();
         @(negedge clk);
         cmp_all();
      end
      for (int c = 0; c <= end_c + 1; c++) begin
         @(posedge clk); #1;
         go = (c <= end_c) ? (go_hold | ($urandom_range(0, 3) == 0)) : go_hold;
         drive_at(c);
         model_at(c);
         @(negedge clk);
         cmp_all();
         if (start_circuit) q_starts.push_back(int'(dataGroupNumber));
         if (done) done_cycle = c;
         if (c == rst_at) begin
            check("dgn_before_reset", 32'(dataGroupNumber), 32'(rst_sample));
            #2 rst_n = 1'b0;
            #1;
            check("async_reset_ctrl", 32'({start_circuit, busy, done, timeout_err, last_match}), 32'd0);
            check("async_reset_data", {dataGroupNumber, correct_count, sample_count, last_pred}, 38'd0);
            go = 1'b0;
            ready_circuit = 1'b1;
            repeat (2) begin
               @(negedge clk);
               check("reset_no_done", 32'({busy, done, start_circuit}), 32'd0);
            end
            rst_n = 1'b1;
            m_dgn = 0; m_cor = 0; m_smp = 0; m_lp = 0; m_lm = 0; m_to = 0;
            return;
         end
      end
      m_dgn = e_dgn; m_cor = e_cor; m_smp = e_smp;
      m_lp = e_lp; m_lm = e_lm; m_to = e_to;
   endtask

   initial begin
      int lbl_d [NS] = '{3, 1, 4, 1, 5, 9, 2, 6};
      int pr_d  [NS] = '{3, 2, 4, 1, 5, 9, 0, 6};
      m_dgn = 0; m_cor = 0; m_smp = 0; m_lp = 0; m_lm = 0; m_to = 0;
      for (int k = 0; k < NS; k++) lbl_rom[k] = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 32'({start_circuit, busy, done, timeout_err, last_match}), 32'd0);
      check("reset_data", {dataGroupNumber, correct_count, sample_count, last_pred}, 38'd0);
      rst_n = 1'b1;

      // Directed run: ready held high through ISSUE plus one more cycle before falling.
      for (int k = 0; k < NS; k++) begin
         lbl_rom[k] = CW'(lbl_d[k]);
         pred[k] = pr_d[k];
         d1[k] = 2;
         d2[k] = 3 + k;
      end
      run_seq(1'b0, 1'b0, -1);
      check("dir_correct_count", 32'(correct_count), 32'd6);
      check("dir_sample_count",  32'(sample_count),  32'd8);
      check("dir_last_pred",     32'(last_pred),     32'd6);
      check("dir_last_match",    32'(last_match),    32'd1);
      check("dir_start_pulses",  32'(q_starts.size()), 32'd8);
      for (int i = 0; i < q_starts.size(); i++)
         check("dir_start_order", 32'(q_starts[i]), 32'(i));

      // Classifier never acknowledges the first start.
      rand_plan();
      d1[0] = TO + 1;
      run_seq(1'b0, 1'b0, -1);
      check("to_err",        32'(timeout_err),  32'd1);
      check("to_samples",    32'(sample_count), 32'd0);
      check("to_done_cycle", 32'(done_cycle),   32'd17);
      check("to_busy",       32'(busy),         32'd0);

      // Waits landing exactly on the last allowed cycle, then a WAIT_DONE overrun.
      rand_plan();
      d1[1] = TO;
      d2[2] = TO;
      d2[3] = TO + 1;
      run_seq(1'b0, 1'b0, -1);
      check("wd_to_samples", 32'(sample_count), 32'd3);
      check("wd_to_err",     32'(timeout_err),  32'd1);

      // go held high across three back-to-back runs.
      rand_plan();
      run_seq(1'b0, 1'b1, -1);
      rand_plan();
      run_seq(1'b1, 1'b1, -1);
      rand_plan();
      run_seq(1'b1, 1'b0, -1);

      repeat (6) begin
         rand_plan();
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) d1[$urandom_range(0, NS - 1)] = TO + $urandom_range(1, 3);
            else                           d2[$urandom_range(0, NS - 1)] = TO + $urandom_range(1, 3);
         end
         run_seq(1'b0, 1'b0, -1);
      end

      // Reset in WAIT_DONE of sample 5, then a clean run to show recovery.
      rand_plan();
      d2[5] = 12;
      run_seq(1'b0, 1'b0, 5);
      rand_plan();
      run_seq(1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
